// File: rtl/multiword_add_seq_pkg.sv
// multiword_add_seq_pkg: shared FSM encoding and index-width helper
package multiword_add_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_e;
  function automatic int idx_w(input int words);
    return words <= 1 ? 1 : $clog2(words);
  endfunction
endpackage

// File: rtl/multiword_add_seq_if.sv
// multiword_add_seq_if: operand/result handshake bundle (in_* request side, out_* result side, busy status)
interface multiword_add_seq_if #(parameter int N = 8, parameter int WORDS = 4);
  logic in_valid;
  logic in_ready;
  logic [N*WORDS-1:0] a;
  logic [N*WORDS-1:0] b;
  logic sub;
  logic cin;
  logic out_valid;
  logic out_ready;
  logic [N*WORDS-1:0] sum;
  logic carry_out;
  logic ovf;
  logic busy;
  modport master (output in_valid, a, b, sub, cin, out_ready, input in_ready, out_valid, sum, carry_out, ovf, busy);
  modport slave (input in_valid, a, b, sub, cin, out_ready, output in_ready, out_valid, sum, carry_out, ovf, busy);
endinterface

// File: rtl/multiword_add_seq_rca.sv
// AdderRCA: N-bit ripple-carry adder slice (a_i + b_i + c_i -> s_o, carry c_o)
module AdderRCA #(parameter int N = 8) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         c_i,
  output logic [N-1:0] s_o,
  output logic         c_o
);
  logic [N:0] c;
  assign c[0] = c_i;
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign s_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign c_o = c[N];
endmodule

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: wide add/sub by sequencing one N-bit adder slice over WORDS cycles, LSW first
// Ports: clk, rst (sync, active-high); bus: slave side of multiword_add_seq_if
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(parameter int N = 8, parameter int WORDS = 4) (
  input logic clk,
  input logic rst,
  multiword_add_seq_if.slave bus
);
  localparam int W = N * WORDS;
  localparam int IW = idx_w(WORDS);
  state_e state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic c_q, c_d, co_q, co_d, ovf_q, ovf_d;
  logic [N-1:0] s;
  logic co;
  AdderRCA #(.N(N)) u_rca (
    .a_i(a_q[idx_q*N +: N]),
    .b_i(b_q[idx_q*N +: N]),
    .c_i(c_q),
    .s_o(s),
    .c_o(co)
  );
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    idx_d = idx_q;
    c_d = c_q;
    co_d = co_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        state_d = RUN;
        a_d = bus.a;
        b_d = bus.sub ? ~bus.b : bus.b;
        c_d = bus.sub | bus.cin;
        idx_d = '0;
      end
      RUN: begin
        sum_d[idx_q*N +: N] = s;
        c_d = co;
        if (idx_q == IW'(WORDS - 1)) begin
          state_d = DONE;
          co_d = co;
          // b_q already holds ~B for subtract, so one rule covers both ops
          ovf_d = (a_q[W-1] == b_q[W-1]) && (sum_d[W-1] != a_q[W-1]);
        end else idx_d = idx_q + 1'b1;
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      idx_q <= '0;
      c_q <= 1'b0;
      co_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      idx_q <= idx_d;
      c_q <= c_d;
      co_q <= co_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.in_ready = (state_q == IDLE) && !rst;
  assign bus.out_valid = state_q == DONE;
  assign bus.busy = state_q != IDLE;
  assign bus.sum = sum_q;
  assign bus.carry_out = co_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_multiword_add_seq.sv
// tb_multiword_add_seq: directed self-checking bench for multiword_add_seq (N=8, WORDS=4)
module tb_multiword_add_seq;
  logic clk = 0;
  logic rst = 1;
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  multiword_add_seq_if #(.N(8), .WORDS(4)) bus ();
  multiword_add_seq #(.N(8), .WORDS(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s, input logic c,
                    input logic [31:0] es, input logic eco, input logic eovf, input int hold);
    int n;
    @(negedge clk);
    check({tag, " in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1; bus.a = a; bus.b = b; bus.sub = s; bus.cin = c;
    @(posedge clk); #1;
    bus.in_valid = 0; bus.a = ~a; bus.b = ~b;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, 4);
    check({tag, " sum"}, bus.sum, es);
    check({tag, " carry_out"}, bus.carry_out, eco);
    check({tag, " ovf"}, bus.ovf, eovf);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      bus.in_valid = (k == 3);
      check({tag, " hold in_ready"}, bus.in_ready, 0);
      @(posedge clk); #1;
      bus.in_valid = 0;
      check({tag, " hold"}, {bus.out_valid, bus.sum, bus.carry_out, bus.ovf}, {1'b1, es, eco, eovf});
    end
    @(negedge clk);
    bus.out_ready = 1;
    @(posedge clk); #1;
    bus.out_ready = 0;
    check({tag, " idle after handshake"}, {bus.busy, bus.out_valid, bus.in_ready}, 3'b001);
  endtask
  logic [31:0] ba [4] = '{32'hAAAAAAAA, 32'h00000010, 32'hDEADBEEF, 32'h80000000};
  logic [31:0] bb [4] = '{32'h55555555, 32'h00000010, 32'h01010101, 32'h80000000};
  logic bs [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] bsum [4] = '{32'hFFFFFFFF, 32'h00000000, 32'hDFAEBFF0, 32'h00000000};
  logic bco [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic bov [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  initial begin
    int t_prev, n;
    bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.sub = 0; bus.cin = 0; bus.out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {bus.sum, bus.carry_out, bus.ovf, bus.out_valid, bus.busy}, 0);
    check("reset in_ready", bus.in_ready, 0);
    @(negedge clk) rst = 0;
    #1 check("in_ready after release", bus.in_ready, 1);
    op("add_ff", 32'h000000FF, 32'h00000001, 0, 0, 32'h00000100, 0, 0, 0);
    op("ripple", 32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0, 0);
    op("ovf", 32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1, 0);
    op("sub", 32'h00000005, 32'h00000007, 1, 1, 32'hFFFFFFFE, 0, 0, 0);
    op("cin", 32'h00000001, 32'h00000001, 0, 1, 32'h00000003, 0, 0, 0);
    op("backpressure", 32'h80000000, 32'h00000001, 1, 0, 32'h7FFFFFFF, 1, 1, 10);
    @(negedge clk);
    bus.in_valid = 1; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF; bus.sub = 0; bus.cin = 0;
    @(posedge clk); #1;
    bus.in_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    check("abort outputs", {bus.sum, bus.carry_out, bus.ovf, bus.out_valid, bus.busy}, 0);
    check("abort in_ready", bus.in_ready, 0);
    @(negedge clk) rst = 0;
    #1 check("abort in_ready release", bus.in_ready, 1);
    n = 0;
    repeat (6) begin
      @(posedge clk); #1;
      n += bus.out_valid;
    end
    check("abort no out_valid", n, 0);
    op("after_abort", 32'h12345678, 32'h11111111, 0, 0, 32'h23456789, 0, 0, 0);
    @(negedge clk);
    bus.in_valid = 1; bus.out_ready = 1;
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!bus.in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("b2b accept wait", n < 20, 1);
      bus.a = ba[k]; bus.b = bb[k]; bus.sub = bs[k]; bus.cin = 0;
      if (k > 0) check("b2b spacing", cyc - t_prev, 6);
      t_prev = cyc;
      @(posedge clk); #1;
      n = 0;
      while (!bus.out_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      check("b2b result", {bus.sum, bus.carry_out, bus.ovf}, {bsum[k], bco[k], bov[k]});
      @(negedge clk);
    end
    bus.in_valid = 0; bus.out_ready = 0;
    repeat (8) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/multiword_add_seq.md
# multiword_add_seq

Sequencer that performs a wide (N*WORDS-bit) add or subtract by time-multiplexing a single N-bit ripple-carry adder slice over WORDS cycles, least-significant word first, chaining carry through a register. It sits between a requester (valid/ready operand port) and a consumer (valid/ready result port). It lets the narrow adder serve wide arithmetic without replicating the carry chain.

## Interface
- N, 8, word width of the adder slice; N >= 1
- WORDS, 4, number of words per operand; WORDS >= 1; total width W = N*WORDS

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand request
- in_ready  output  1  block can accept an operation
- a  input  W  operand A
- b  input  W  operand B
- sub  input  1  0: A+B+cin; 1: A-B (cin ignored)
- cin  input  1  carry in for add
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- sum  output  W  result
- carry_out  output  1  carry out of MSB; for sub, 1 = no borrow
- ovf  output  1  signed two's-complement overflow
- busy  output  1  operation in flight (RUN or DONE)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. Accept on in_valid&&in_ready: latch a into a_reg; latch b into b_reg, or ~b if sub=1; carry_reg <= sub ? 1 : cin; idx <= 0; go to RUN. Inputs are ignored when not accepted.
- RUN: each cycle, slice adds a_reg word idx, b_reg word idx, and carry_reg.
  - Write the slice sum into sum word idx; carry_reg <= slice carry out.
  - If idx==WORDS-1: go to DONE, capture carry_out, and compute ovf. Otherwise idx <= idx+1.
- ovf = (a_reg[W-1] == b_reg[W-1]) && (sum[W-1] != a_reg[W-1]), using the already-inverted b_reg.
- DONE: out_valid=1. sum, carry_out and ovf are held stable. On out_ready, go to IDLE.
- in_ready=0 in RUN and DONE. in_valid is ignored there, so no queueing occurs.
- sum contents during RUN are partial and undefined to the consumer. Only the value while out_valid=1 is meaningful.
- WORDS=1: a single RUN cycle; all rules unchanged.
- Sub: carry_out=0 means a borrow occurred (A<B unsigned).

## Timing
- Reset (rst high at an edge): state <= IDLE; sum, carry_out, ovf, idx and carry_reg <= 0.
  - out_valid=0, busy=0.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after rst is low.
- Reset mid-operation (RUN or DONE): the operation is discarded and no out_valid is produced for it.
- Latency: operation accepted at edge E0. RUN occupies edges E1..E_WORDS. out_valid is high from just after E_WORDS, i.e. WORDS cycles after the accept edge.
- Handshake completes at the edge where out_valid&&out_ready are both high; state is IDLE after that edge.
- Minimum issue interval: WORDS+2 cycles with out_ready held high (accept, WORDS RUN cycles, result handshake cycle).
- out_valid, once high, stays high with stable outputs until the handshake completes. out_ready is ignored outside DONE.
- in_ready and out_valid are decoded from state registers only; there is no combinational path from in_valid or out_ready.

## Structure
- Shared package: state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the index-width function (clog2 of WORDS, minimum 1).
- One sub-module: the team's existing N-bit ripple-carry adder slice, AdderRCA with parameter N, instantiated once. Word muxing, carry register, FSM and result register are in this block.

## Test plan
All cases use N=8, WORDS=4.
- Add 0x000000FF + 0x00000001, cin=0 -> sum=0x00000100, carry_out=0, ovf=0; out_valid exactly 4 cycles after accept.
- Full ripple: 0xFFFFFFFF + 0x00000001 -> sum=0x00000000, carry_out=1, ovf=0. Then 0x7FFFFFFF + 0x00000001 -> 0x80000000, carry_out=0, ovf=1.
- Sub 0x00000005 - 0x00000007 with cin=1 -> sum=0xFFFFFFFE, carry_out=0, ovf=0 (cin ignored). Add 0x1 + 0x1 with cin=1 -> 0x00000003.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, sum, carry_out and ovf are held; in_ready=0. An in_valid pulse with new operands is not accepted. Releasing out_ready gives IDLE next cycle.
- Reset during RUN at idx=2 -> outputs zero after the reset edge, no out_valid for the aborted op, in_ready=1 after release. A following 0x12345678 + 0x11111111 gives 0x23456789.
- Back-to-back with in_valid and out_ready held high -> accepts spaced exactly 6 cycles apart, all results correct.
